t06_tick_scheduler: RTL and testbench

T06_TICK_SCHEDULER -- requirements
Module: t06_tick_scheduler

---
 rtl/t06_tick_scheduler.sv | 153 +++++++++++++++
 tb/tb_t06_tick_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/t06_tick_scheduler.sv
// Four-channel periodic tick scheduler with round-robin valid/ready tick offer.
// Optional lost-event tracking is enabled by defining T06_TICK_SCHED_OVERRUN_EN.
module t06_tick_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_en,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic [3:0]       ch_en,
  input  logic             tick_ready,
  output logic             tick_valid,
  output logic [1:0]       tick_id,
  output logic [3:0]       pending,
  output logic [3:0]       overrun
);

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] period_reg [4];
  logic [CNT_W-1:0] cnt_reg    [4];
  logic [3:0]       pending_reg;
  logic             tick_valid_reg;
  logic [1:0]       tick_id_reg;
  logic [1:0]       last_grant_reg;

  logic             grant_found;
  logic [1:0]       grant_id;
  logic [1:0]       cand;
  logic             handshake;
  logic [3:0]       cfg_hit;
  logic [3:0]       expire;
  logic [3:0]       hold_offer;
  logic [3:0]       clear_hit;

  assign handshake = (state_reg == ST_OFFER) && tick_ready;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last_grant_reg + 2'(k + 1);
      if (!grant_found && pending_reg[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      assign cfg_hit[gi]   = cfg_we && (cfg_addr == 2'(gi));
      assign expire[gi]    = base_en && ch_en[gi] && !cfg_hit[gi] &&
                             (cnt_reg[gi] == period_reg[gi]);
      // A channel being granted or offered keeps its pending bit through a ch_en drop.
      assign hold_offer[gi] = ((state_reg == ST_OFFER) && (tick_id_reg == 2'(gi))) ||
                              ((state_reg == ST_IDLE) && grant_found && (grant_id == 2'(gi)));
      assign clear_hit[gi] = handshake && (tick_id_reg == 2'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          period_reg[gi]  <= '1;
          cnt_reg[gi]     <= '0;
          pending_reg[gi] <= 1'b0;
        end else begin
          if (cfg_hit[gi]) begin
            period_reg[gi] <= cfg_wdata;
            cnt_reg[gi]    <= '0;
          end else if (!ch_en[gi] || expire[gi]) begin
            cnt_reg[gi] <= '0;
          end else if (base_en) begin
            cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
          end

          // Expiry wins over the handshake clear so a coincident event is not lost.
          if (!ch_en[gi] && !hold_offer[gi]) begin
            pending_reg[gi] <= 1'b0;
          end else if (expire[gi]) begin
            pending_reg[gi] <= 1'b1;
          end else if (clear_hit[gi]) begin
            pending_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      tick_valid_reg <= 1'b0;
      tick_id_reg    <= 2'd0;
      last_grant_reg <= 2'd3;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_found) begin
            state_reg      <= ST_OFFER;
            tick_valid_reg <= 1'b1;
            tick_id_reg    <= grant_id;
            last_grant_reg <= grant_id;
          end
        end
        ST_OFFER: begin
          if (tick_ready) begin
            state_reg      <= ST_IDLE;
            tick_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= ST_IDLE;
          tick_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef T06_TICK_SCHED_OVERRUN_EN
  logic [3:0] lost;
  logic [3:0] overrun_reg;

  assign lost = expire & pending_reg & ~clear_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cfg_hit[i]) begin
          overrun_reg[i] <= 1'b0;
        end else if (lost[i]) begin
          overrun_reg[i] <= 1'b1;
        end
      end
    end
  end

  assign overrun = overrun_reg;
`else
  assign overrun = 4'b0000;
`endif

  assign tick_valid = tick_valid_reg;
  assign tick_id    = tick_id_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_t06_tick_scheduler.sv
// Directed self-checking bench for t06_tick_scheduler; one task per scenario.
module tb_t06_tick_scheduler;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             base_en;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic [3:0]       ch_en;
  logic             tick_ready;
  logic             tick_valid;
  logic [1:0]       tick_id;
  logic [3:0]       pending;
  logic [3:0]       overrun;

  int checks = 0;
  int errors = 0;

  t06_tick_scheduler #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .base_en    (base_en),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .ch_en      (ch_en),
    .tick_ready (tick_ready),
    .tick_valid (tick_valid),
    .tick_id    (tick_id),
    .pending    (pending),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; base_en = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = '0; ch_en = 4'b0000; tick_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [CNT_W-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tick_valid); end
    checks++; if (tick_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", tick_id); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b want 0000", pending); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun got %b want 0000", overrun); end
    $display("test_reset: valid=%b id=%0d pending=%b overrun=%b", tick_valid, tick_id, pending, overrun);
  endtask

  task automatic test_period();
    logic exp_v;
    apply_reset();
    cfg_write(2'd0, 16'd3);
    ch_en = 4'b0001; base_en = 1'b1; tick_ready = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      tick();
      exp_v = (n >= 5) && (((n - 5) % 4) == 0);
      checks++;
      if (tick_valid !== exp_v) begin
        errors++; $display("FAIL period_valid cycle %0d got %b want %b", n, tick_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (tick_id !== 2'd0) begin errors++; $display("FAIL period_id cycle %0d got %0d want 0", n, tick_id); end
      end
      $display("test_period: cycle %0d valid=%b id=%0d", n, tick_valid, tick_id);
    end
    ch_en = 4'b0000; base_en = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic       exp_v;
    logic [1:0] exp_id;
    apply_reset();
    for (int c = 0; c < 4; c++) cfg_write(2'(c), '0);
    ch_en = 4'b1111; base_en = 1'b1; tick_ready = 1'b1;
    tick();
    base_en = 1'b0;
    checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL rr_pending got %b want 1111", pending); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v  = (k % 2) == 1;
      exp_id = 2'((k - 1) / 2);
      checks++;
      if (tick_valid !== exp_v) begin errors++; $display("FAIL rr_valid step %0d got %b want %b", k, tick_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (tick_id !== exp_id) begin errors++; $display("FAIL rr_id step %0d got %0d want %0d", k, tick_id, exp_id); end
      end
      $display("test_round_robin: step %0d valid=%b id=%0d pending=%b", k, tick_valid, tick_id, pending);
    end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rr_drain got %b want 0000", pending); end
    ch_en = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_ovr;
`ifdef T06_TICK_SCHED_OVERRUN_EN
    exp_ovr = 4'b0100;
`else
    exp_ovr = 4'b0000;
`endif
    apply_reset();
    cfg_write(2'd2, 16'd1);
    ch_en = 4'b0100; base_en = 1'b1; tick_ready = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 2) begin
        checks++;
        if (pending !== 4'b0100) begin errors++; $display("FAIL bp_pending got %b want 0100", pending); end
      end
      if (n >= 3) begin
        checks++;
        if (tick_valid !== 1'b1 || tick_id !== 2'd2) begin
          errors++; $display("FAIL bp_hold cycle %0d got valid=%b id=%0d want valid=1 id=2", n, tick_valid, tick_id);
        end
      end
    end
    checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL bp_overrun got %b want %b", overrun, exp_ovr); end
    $display("test_backpressure: held id=%0d overrun=%b", tick_id, overrun);
    tick_ready = 1'b1;
    tick();
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", tick_valid); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL bp_release_pending got %b want 0000", pending); end
    checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL bp_sticky got %b want %b", overrun, exp_ovr); end
    ch_en = 4'b0000; base_en = 1'b0;
    cfg_write(2'd2, 16'd1);
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL bp_cfg_clear got %b want 0000", overrun); end
    $display("test_backpressure: after cfg write overrun=%b", overrun);
  endtask

  task automatic test_write_collision();
    apply_reset();
    cfg_write(2'd1, 16'd2);
    ch_en = 4'b0010; base_en = 1'b1; tick_ready = 1'b0;
    tick();
    tick();
    cfg_write(2'd1, 16'd2);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL wc_no_expiry got %b want 0000", pending); end
    tick();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL wc_cnt1 got %b want 0000", pending); end
    tick();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL wc_cnt2 got %b want 0000", pending); end
    tick();
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL wc_expiry got %b want 0010", pending); end
    tick();
    checks++; if (tick_valid !== 1'b1 || tick_id !== 2'd1) begin
      errors++; $display("FAIL wc_offer got valid=%b id=%0d want valid=1 id=1", tick_valid, tick_id);
    end
    $display("test_write_collision: pending=%b valid=%b id=%0d", pending, tick_valid, tick_id);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    cfg_write(2'd3, 16'd1);
    ch_en = 4'b1000; base_en = 1'b1; tick_ready = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (tick_valid !== 1'b1 || tick_id !== 2'd3) begin
      errors++; $display("FAIL sim_first got valid=%b id=%0d want valid=1 id=3", tick_valid, tick_id);
    end
    tick_ready = 1'b1;
    tick();
    checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL sim_pending got %b want 1", pending[3]); end
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL sim_gap got %b want 0", tick_valid); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL sim_overrun got %b want 0000", overrun); end
    tick();
    checks++; if (tick_valid !== 1'b1 || tick_id !== 2'd3) begin
      errors++; $display("FAIL sim_second got valid=%b id=%0d want valid=1 id=3", tick_valid, tick_id);
    end
    $display("test_simultaneous: pending=%b valid=%b id=%0d overrun=%b", pending, tick_valid, tick_id, overrun);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    cfg_write(2'd0, '0);
    cfg_write(2'd1, '0);
    ch_en = 4'b0011; base_en = 1'b1; tick_ready = 1'b0;
    tick();
    base_en = 1'b0;
    checks++; if (pending !== 4'b0011) begin errors++; $display("FAIL mr_pending got %b want 0011", pending); end
    tick();
    checks++; if (tick_valid !== 1'b1 || tick_id !== 2'd0) begin
      errors++; $display("FAIL mr_offer got valid=%b id=%0d want valid=1 id=0", tick_valid, tick_id);
    end
    rst = 1'b1; tick_ready = 1'b1;
    tick();
    rst = 1'b0; tick_ready = 1'b0;
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", tick_valid); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mr_pending_clr got %b want 0000", pending); end
    cfg_write(2'd0, '0);
    cfg_write(2'd1, '0);
    base_en = 1'b1;
    tick();
    base_en = 1'b0;
    tick();
    checks++; if (tick_valid !== 1'b1 || tick_id !== 2'd0) begin
      errors++; $display("FAIL mr_next_grant got valid=%b id=%0d want valid=1 id=0", tick_valid, tick_id);
    end
    $display("test_mid_reset: next grant valid=%b id=%0d", tick_valid, tick_id);
  endtask

  initial begin
    rst = 1'b1; base_en = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = '0; ch_en = 4'b0000; tick_ready = 1'b0;
    test_reset();
    test_period();
    test_round_robin();
    test_backpressure();
    test_write_collision();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
